// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tetris_pkg
// Purpose  : Shared piece type, constants and state encoding for the bag gen.
// Revision : 1.0
// ============================================================================
package tetris_pkg;

    typedef logic [2:0] piece_t;

    localparam piece_t PIECE_NONE = 3'o7;
    localparam int     NUM_PIECES = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_READY  = 2'd2,
        ST_REFILL = 2'd3
    } state_t;

    // One-hot bag bit for a piece; the "none" code maps to no bit.
    function automatic logic [NUM_PIECES-1:0] piece_bit(input piece_t p);
        piece_bit = '0;
        if (p != PIECE_NONE) begin
            piece_bit[p] = 1'b1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Purpose  : 16-bit Galois LFSR (taps 16,14,13,11), free-running out of reset.
// Revision : 1.0
// ============================================================================
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [15:0] q
);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
        end
    end

endmodule
`default_nettype wire

// File: rtl/piece_bag_gen.sv
`default_nettype none
// ============================================================================
// Module   : piece_bag_gen
// Purpose  : Upcoming-piece queue filled from an LFSR, with optional 7-bag.
// Revision : 1.0
// ============================================================================
module piece_bag_gen
    import tetris_pkg::*;
#(
    parameter int          DEPTH    = 3,
    parameter int          BAG_MODE = 1,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               NEXT,
    output logic               READY,
    output logic [2:0]         piece_type,
    output logic [3*DEPTH-1:0] preview
);

    localparam logic [2:0] c_LAST_SLOT = 3'(DEPTH - 1);

    state_t                r_state, w_state_nxt;
    piece_t                r_slot     [DEPTH];
    piece_t                w_slot_nxt [DEPTH];
    logic [NUM_PIECES-1:0] r_used, w_used_nxt, w_used_acc;
    logic [2:0]            r_cnt, w_cnt_nxt;
    logic [15:0]           w_lfsr;
    piece_t                w_cand;
    logic                  w_accept;
    logic                  w_unused_lfsr;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .CLK   (CLK),
        .RESET (RESET),
        .q     (w_lfsr)
    );

    assign w_cand        = w_lfsr[2:0];
    assign w_unused_lfsr = ^w_lfsr[15:3];
    assign w_accept      = (w_cand != PIECE_NONE) &&
                           ((BAG_MODE == 0) || ((r_used & piece_bit(w_cand)) == '0));

    // The seventh piece of a bag empties the mask in the same cycle.
    always_comb begin
        w_used_acc = r_used | piece_bit(w_cand);
        if ((BAG_MODE == 0) || (w_used_acc == '1)) begin
            w_used_acc = '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_used_nxt  = r_used;
        w_cnt_nxt   = r_cnt;
        w_slot_nxt  = r_slot;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_nxt = ST_FILL;
                    w_cnt_nxt   = '0;
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (r_cnt == 3'(i)) begin
                            w_slot_nxt[i] = w_cand;
                        end
                    end
                    w_used_nxt = w_used_acc;
                    w_cnt_nxt  = r_cnt + 3'd1;
                    if (r_cnt == c_LAST_SLOT) begin
                        w_state_nxt = ST_READY;
                    end
                end
            end
            ST_READY: begin
                if (!START) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        w_slot_nxt[i] = PIECE_NONE;
                    end
                    w_used_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end else if (NEXT) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        w_slot_nxt[i] = r_slot[i+1];
                    end
                    w_slot_nxt[DEPTH-1] = PIECE_NONE;
                    w_state_nxt         = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (!START) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        w_slot_nxt[i] = PIECE_NONE;
                    end
                    w_used_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_accept) begin
                    w_slot_nxt[DEPTH-1] = w_cand;
                    w_used_nxt          = w_used_acc;
                    w_state_nxt         = ST_READY;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_used  <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= PIECE_NONE;
            end
        end else begin
            r_state <= w_state_nxt;
            r_used  <= w_used_nxt;
            r_cnt   <= w_cnt_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= w_slot_nxt[i];
            end
        end
    end

    assign READY      = (r_state == ST_READY);
    assign piece_type = r_slot[0];

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_prev
            if (k < DEPTH - 1) begin : g_slot
                assign preview[3*k +: 3] = r_slot[k+1];
            end else begin : g_none
                assign preview[3*k +: 3] = PIECE_NONE;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_piece_bag_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_piece_bag_gen
// Purpose  : Self-checking bench for piece_bag_gen (bag and uniform instances).
// Revision : 1.0
// ============================================================================
module tb_piece_bag_gen;

    typedef struct {
        logic rst;
        logic start;
        logic next;
        logic exp_ready;
        logic exp_empty;
    } vec_t;

    typedef struct {
        logic [2:0] head;
        logic [2:0] slot1;
    } sb_t;

    logic       clk;
    logic       rst;
    logic       startA, nextA, readyA;
    logic [2:0] ptA;
    logic [8:0] prevA;
    logic       startB, nextB, readyB;
    logic [2:0] ptB;
    logic [8:0] prevB;

    int         n_tests;
    int         n_fail;
    vec_t       tbl [5];
    sb_t        sb_q [$];
    logic [2:0] gen_q [$];
    sb_t        e;
    logic [2:0] exp_fill [3];
    logic [15:0] lf;
    logic [6:0] used;
    logic [6:0] mask;
    logic [2:0] c, p1, p2;
    int         k, n, cyc, w, expB;
    int         cnt [8];

    piece_bag_gen #(.DEPTH(3), .BAG_MODE(1), .SEED(16'hACE1)) u_dut_bag (
        .CLK(clk), .RESET(rst), .START(startA), .NEXT(nextA),
        .READY(readyA), .piece_type(ptA), .preview(prevA)
    );

    piece_bag_gen #(.DEPTH(3), .BAG_MODE(0), .SEED(16'hACE1)) u_dut_uni (
        .CLK(clk), .RESET(rst), .START(startB), .NEXT(nextB),
        .READY(readyB), .piece_type(ptB), .preview(prevB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] lstep(input logic [15:0] x);
        lstep = {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_ready_a();
        w = 0;
        while (!readyA && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!readyA) check("readyA_timeout", 0, 1);
    endtask

    // Pop the head of the bag instance; the scoreboard holds what the queue must show next.
    task automatic pop_a();
        wait_ready_a();
        if (!readyA) return;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_head", int'(ptA), int'(e.head));
            check("sb_slot1", int'(prevA[2:0]), int'(e.slot1));
        end
        gen_q.push_back(ptA);
        sb_q.push_back('{prevA[2:0], prevA[5:3]});
        nextA = 1'b1;
        @(negedge clk);
        nextA = 1'b0;
    endtask

    task automatic check_perm(input string name, input int base);
        mask = '0;
        for (int j = 0; j < 7; j++) begin
            if (gen_q[base+j] != 3'o7) mask[gen_q[base+j]] = 1'b1;
        end
        check(name, int'(mask), 7'h7F);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; startA = 1'b0; nextA = 1'b0; startB = 1'b0; nextB = 1'b0;
        for (int i = 0; i < 8; i++) cnt[i] = 0;

        //           rst   start next  ready empty
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rst = tbl[i].rst; startA = tbl[i].start; nextA = tbl[i].next;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), int'(readyA), int'(tbl[i].exp_ready));
            check($sformatf("vec%0d_empty", i),
                  int'(ptA == 3'o7 && prevA == 9'h1FF), int'(tbl[i].exp_empty));
        end
        nextA = 1'b0;

        // First fill after reset: model the candidate stream starting one step past SEED.
        lf = lstep(16'hACE1); used = '0; k = 0; n = 0;
        while (n < 3) begin
            c = lf[2:0];
            if (c != 3'o7 && !used[c]) begin
                exp_fill[n] = c;
                used[c] = 1'b1;
                n++;
            end
            lf = lstep(lf);
            k++;
        end
        rst = 1'b0; startA = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!readyA && cyc < 100);
        check("fill_ready", int'(readyA), 1);
        check("fill_latency", cyc, 1 + k);
        check_range("fill_latency_min", cyc, 3, 1000);
        check("fill_head", int'(ptA), int'(exp_fill[0]));
        check("fill_slot1", int'(prevA[2:0]), int'(exp_fill[1]));
        check("fill_slot2", int'(prevA[5:3]), int'(exp_fill[2]));
        check("fill_distinct", int'(ptA != prevA[2:0] && ptA != prevA[5:3] &&
                                    prevA[2:0] != prevA[5:3]), 1);

        // NEXT held into the Refill cycle must not cause a second shift.
        p1 = prevA[2:0]; p2 = prevA[5:3];
        gen_q.push_back(ptA);
        sb_q.push_back('{p1, p2});
        nextA = 1'b1;
        @(negedge clk);
        check("refill_ready_low", int'(readyA), 0);
        check("shift_head", int'(ptA), int'(p1));
        check("shift_slot1", int'(prevA[2:0]), int'(p2));
        check("shift_tail_none", int'(prevA[5:3]), 7);
        @(negedge clk);
        nextA = 1'b0;

        for (int i = 0; i < 69; i++) pop_a();
        check("bag_count", gen_q.size(), 70);
        if (gen_q.size() == 70) begin
            for (int g = 0; g < 10; g++) check_perm($sformatf("bag_perm_g%0d", g), g * 7);
        end

        // START dropped in Ready: clears everything, and the next fill starts a fresh bag.
        wait_ready_a();
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_head_last", int'(ptA), int'(e.head));
        end
        startA = 1'b0;
        @(negedge clk);
        check("drop_ready", int'(readyA), 0);
        check("drop_head", int'(ptA), 7);
        check("drop_preview", int'(prevA), 9'h1FF);
        startA = 1'b1;
        sb_q.delete();
        gen_q.delete();
        for (int i = 0; i < 7; i++) pop_a();
        check("fresh_count", gen_q.size(), 7);
        if (gen_q.size() == 7) check_perm("fresh_bag_perm", 0);

        // Uniform instance.
        startB = 1'b1;
        expB = -1;
        for (int i = 0; i < 700; i++) begin
            w = 0;
            while (!readyB && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!readyB) begin
                check("readyB_timeout", 0, 1);
                break;
            end
            if (expB >= 0) check("sbB_head", int'(ptB), expB);
            cnt[ptB]++;
            expB = int'(prevB[2:0]);
            nextB = 1'b1;
            @(negedge clk);
            nextB = 1'b0;
        end
        check("uniform_no7", cnt[7], 0);
        for (int p = 0; p < 7; p++) check_range($sformatf("uniform_cnt%0d", p), cnt[p], 60, 140);

        // Reset asserted mid-fill acts without a clock edge.
        startA = 1'b0;
        @(negedge clk);
        startA = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midfill_not_ready", int'(readyA), 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_ready", int'(readyA), 0);
        check("async_head", int'(ptA), 7);
        check("async_preview", int'(prevA), 9'h1FF);
        @(negedge clk);
        startA = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_reset_ready", int'(readyA), 0);
        check("post_reset_empty", int'(ptA == 3'o7 && prevA == 9'h1FF), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piece_bag_gen.md
PIECE_BAG_GEN -- requirements
Module: piece_bag_gen

Interface
REQ-001 Parameter DEPTH, default 3: number of upcoming pieces held in the queue; legal range 1..6.
REQ-002 Parameter BAG_MODE, default 1: 1 = 7-bag generation, 0 = uniform-random generation.
REQ-003 Parameter SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-004 CLK  input  1  single system clock; all state changes on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 START  input  1  level; high starts the queue fill from the Idle state.
REQ-007 NEXT  input  1  single-cycle pop request; ignored unless READY=1.
REQ-008 READY  output  1  queue full and head valid.
REQ-009 piece_type  output  3  queue head; encoding 0..6 = piece, 3'o7 = none.
REQ-010 preview  output  3*DEPTH  queue slots 1..DEPTH-1 packed, slot 1 in the LSBs; unused upper bits 3'o7.

Function
REQ-011 A 16-bit Galois LFSR (taps 16,14,13,11) advances every cycle when not in reset; candidate = LFSR[2:0].
REQ-012 A candidate of 3'o7 is rejected in both modes.
REQ-013 In BAG_MODE=1, a candidate whose bit is set in the 7-bit used mask is rejected; an accepted candidate sets its bit.
REQ-014 When the used mask reaches 7'h7F, it clears in the same cycle as the seventh acceptance.
REQ-015 In BAG_MODE=0, every candidate other than 7 is accepted.
REQ-016 States: Idle, Fill, Ready, Refill.
REQ-017 Idle: READY=0, all slots 3'o7; START=1 -> Fill.
REQ-018 Fill: each accepted candidate is written to the lowest empty slot; when slot DEPTH-1 is written -> Ready.
REQ-019 Ready: READY=1; NEXT=1 -> the queue shifts down one slot, the tail slot becomes 3'o7, and the state goes to Refill in the same edge.
REQ-020 Refill: READY=0; the first accepted candidate is written to the tail slot -> Ready.
REQ-021 A NEXT asserted in Idle, Fill or Refill is dropped and is not queued.
REQ-022 START=0 in Ready or Refill -> Idle, with the queue cleared and the used mask cleared.
REQ-023 In Fill, START=0 has no effect until the fill completes.
REQ-024 Latency from START to READY is at least DEPTH cycles.
REQ-025 Latency from a NEXT pop to READY is at least 1 cycle.
REQ-026 piece_type and preview are registered outputs; they change only on the clock edge after an accepted write or shift.

Reset
REQ-027 RESET forces, asynchronously and at any time including mid-Fill or mid-Refill, the following:
- state = Idle
- LFSR = SEED
- used mask = 0
- all slots = 3'o7
- READY = 0
- piece_type = 3'o7

Structure
REQ-028 Package tetris_pkg holds:
- the piece_t typedef (3 bits)
- constant PIECE_NONE = 3'o7
- constant NUM_PIECES = 7
- the state enum
REQ-029 The LFSR is a sub-module, lfsr16, with ports CLK, RESET, SEED parameter, and output q[15:0]; the queue and the bag logic stay in piece_bag_gen.

Verification
REQ-030 Reset during Fill, with the queue partially filled:
- stimulus: RESET asserted
- response: READY=0, piece_type=7 and preview all 7 immediately, without waiting for CLK; Idle after release.
REQ-031 Fill, DEPTH=3, START held:
- READY rises at least 3 cycles after START
- piece_type and both preview slots lie in 0..6
- in BAG_MODE=1 the three values are distinct
REQ-032 Bag property, BAG_MODE=1: 70 consecutive pops with NEXT pulsed whenever READY=1 -> every aligned group of 7 generated pieces is a permutation of 0..6.
REQ-033 Uniform mode, BAG_MODE=0: 700 pops -> no value 7 appears and each piece count lies within 60..140.
REQ-034 NEXT pulsed in Refill (the cycle after a pop) -> the pulse is ignored, exactly one shift occurs, and old preview slot 1 appears as piece_type.
REQ-035 START dropped in Ready -> next cycle Idle, READY=0, all slots 7; START raised again -> a new fill starts, and the bag mask is fresh.
